// File: rtl/alu_sel_pkg.sv
// Shared types and constants for the ALU result-select pipeline.
package alu_sel_pkg;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Width of one buffered entry: {data, sel, err}.
    function automatic int entry_w(input int n, input int sel_w);
        return n + sel_w + 1;
    endfunction

    // Source map of the default 20-source ALU.
    localparam int         ALU_NUM_SRC = 20;
    localparam int         ALU_SEL_W   = 5;
    localparam logic [4:0] SEL_ADD     = 5'd0;
    localparam logic [4:0] SEL_SUB     = 5'd1;
    localparam logic [4:0] SEL_AND     = 5'd2;
    localparam logic [4:0] SEL_OR      = 5'd3;
    localparam logic [4:0] SEL_XOR     = 5'd4;
    localparam logic [4:0] SEL_NOT     = 5'd5;
    localparam logic [4:0] SEL_SHL     = 5'd6;
    localparam logic [4:0] SEL_SHR     = 5'd7;
    localparam logic [4:0] SEL_SAR     = 5'd8;
    localparam logic [4:0] SEL_ROL     = 5'd9;
    localparam logic [4:0] SEL_ROR     = 5'd10;
    localparam logic [4:0] SEL_MUL_LO  = 5'd11;
    localparam logic [4:0] SEL_MUL_HI  = 5'd12;
    localparam logic [4:0] SEL_CMP     = 5'd13;
    localparam logic [4:0] SEL_MIN     = 5'd14;
    localparam logic [4:0] SEL_MAX     = 5'd15;
    localparam logic [4:0] SEL_ABS     = 5'd16;
    localparam logic [4:0] SEL_POPCNT  = 5'd17;
    localparam logic [4:0] SEL_CLZ     = 5'd18;
    localparam logic [4:0] SEL_PASS    = 5'd19;

endpackage

// File: rtl/alu_src_decode.sv
// Combinational source select with range check: out-of-range selects
// yield zero data and raise err.
module alu_src_decode
    import alu_sel_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int NUM_SRC = 20,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM_SRC*N-1:0] src,
    output logic [N-1:0]         data,
    output logic                 err
);

    // One-hot compare per channel; no match means sel is past the last source.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                data = src[k*N +: N];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// ALU result-select stage: decodes the selected source at accept time and
// hands {data, sel, err} downstream through a two-entry skid buffer.
module alu_result_sel_pipe
    import alu_sel_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int NUM_SRC = 20,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM_SRC*N-1:0] src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic                 err_sticky
);

    localparam int EW = entry_w(N, SEL_W);

    buf_state_t    state;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;
    logic [EW-1:0] new_entry;
    logic [N-1:0]  dec_data;
    logic          dec_err;
    logic          accept;
    logic          pop;

    alu_src_decode #(
        .N       (N),
        .NUM_SRC (NUM_SRC)
    ) u_decode (
        .sel  (sel),
        .src  (src),
        .data (dec_data),
        .err  (dec_err)
    );

    assign new_entry = {dec_data, sel, dec_err};

    // Handshake flags come straight from the state register, so in_ready
    // never depends on out_ready within a cycle.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_data, out_sel, out_err} = main_q;

    // Buffer FSM, entry storage and sticky error; a new error wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (accept && dec_err)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;

            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= new_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_q <= new_entry;
                        state  <= TWO;
                    end else if (accept && pop) begin
                        main_q <= new_entry;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench for alu_result_sel_pipe with an in-order scoreboard.
module tb_alu_result_sel_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic [4:0] s;
        logic       e;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   sel, out_sel;
    logic [159:0] src;
    logic [7:0]   out_data;
    logic         out_err, err_clr, err_sticky;

    logic         p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [2:0]   p_sel, p_out_sel;
    logic [79:0]  p_src;
    logic [15:0]  p_out_data;
    logic         p_out_err, p_err_clr, p_err_sticky;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    logic exp_sticky;

    always #5 clk = ~clk;

    alu_result_sel_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .src(src),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
        .err_clr(err_clr), .err_sticky(err_sticky)
    );

    alu_result_sel_pipe #(.N(16), .NUM_SRC(5)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .sel(p_sel), .src(p_src),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_data(p_out_data), .out_sel(p_out_sel), .out_err(p_out_err),
        .err_clr(p_err_clr), .err_sticky(p_err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model(input logic [4:0] s, input logic [159:0] v);
        ent_t r;
        r.s = s;
        if (s < 5'd20) begin
            r.d = v[int'(s)*8 +: 8];
            r.e = 1'b0;
        end else begin
            r.d = 8'h00;
            r.e = 1'b1;
        end
        return r;
    endfunction

    task automatic set_all(input logic [7:0] v);
        for (int k = 0; k < 20; k++) src[k*8 +: 8] = v;
    endtask

    // One clock: score the pop/accept seen before the edge, then step past it.
    task automatic cyc();
        ent_t e;
        ent_t n;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("pop_data", {24'd0, out_data}, {24'd0, e.d});
                chk("pop_sel",  {27'd0, out_sel},  {27'd0, e.s});
                chk("pop_err",  {31'd0, out_err},  {31'd0, e.e});
            end
        end
        n = model(sel, src);
        if (in_valid && in_ready) begin
            q.push_back(n);
            if (n.e) exp_sticky = 1'b1;
            else if (err_clr) exp_sticky = 1'b0;
        end else if (err_clr) begin
            exp_sticky = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, exp_sticky});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0; src = '0; err_clr = 1'b0;
        p_in_valid = 1'b0; p_out_ready = 1'b0; p_sel = '0; p_src = '0; p_err_clr = 1'b0;
        exp_sticky = 1'b0;

        // Reset state.
        #12;
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_out_data",   {24'd0, out_data},   32'd0);
        chk("rst_out_sel",    {27'd0, out_sel},    32'd0);
        chk("rst_out_err",    {31'd0, out_err},    32'd0);
        chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        rst_n = 1'b1;

        // Basic select, accepted on the first edge after reset release.
        set_all(8'hFF);
        src[3*8 +: 8] = 8'hA5;
        sel = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_data",  {24'd0, out_data},  32'hA5);
        chk("basic_sel",   {27'd0, out_sel},   32'd3);
        chk("basic_err",   {31'd0, out_err},   32'd0);
        in_valid = 1'b0;
        cyc();
        chk("basic_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: two entries fill the buffer, the third is held off.
        out_ready = 1'b0;
        set_all(8'h00);
        src[0*8 +: 8] = 8'h11; sel = 5'd0; in_valid = 1'b1;
        cyc();
        src[0*8 +: 8] = 8'h99;
        src[1*8 +: 8] = 8'h22; sel = 5'd1;
        cyc();
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        src[2*8 +: 8] = 8'h33; sel = 5'd2;
        cyc();
        chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_stable_data",   {24'd0, out_data}, 32'h11);
        cyc();
        chk("bp_stable_data2",  {24'd0, out_data}, 32'h11);
        out_ready = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("bp_queue_empty", q.size(), 32'd0);
        chk("bp_drained",     {31'd0, out_valid}, 32'd0);

        // Error path and sticky set/clear priority.
        sel = 5'd20; in_valid = 1'b1;
        cyc();
        chk("err_data", {24'd0, out_data}, 32'h00);
        chk("err_flag", {31'd0, out_err},  32'd1);
        chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
        in_valid = 1'b0; err_clr = 1'b1;
        cyc();
        chk("err_sticky_clr", {31'd0, err_sticky}, 32'd0);
        sel = 5'd25; in_valid = 1'b1;
        cyc();
        chk("err_set_wins", {31'd0, err_sticky}, 32'd1);
        in_valid = 1'b0; err_clr = 1'b0;
        cyc();

        // Streaming: one result per cycle, in_ready never drops.
        for (int k = 0; k < 20; k++) src[k*8 +: 8] = 8'(k + 1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sel = 5'(k);
            cyc();
            chk("stream_in_ready", {31'd0, in_ready},  32'd1);
            chk("stream_valid",    {31'd0, out_valid}, 32'd1);
            chk("stream_data",     {24'd0, out_data},  32'(k + 1));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_queue_empty", q.size(), 32'd0);

        // Async reset while full: outputs clear before the next edge.
        out_ready = 1'b0; sel = 5'd20; in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("arst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("arst_err_sticky", {31'd0, err_sticky}, 32'd0);
        chk("arst_out_data",   {24'd0, out_data},   32'd0);
        q.delete();
        exp_sticky = 1'b0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("arst_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Parametric instance N=16, NUM_SRC=5.
        for (int k = 0; k < 5; k++) p_src[k*16 +: 16] = 16'h1234;
        p_src[4*16 +: 16] = 16'hBEEF;
        p_out_ready = 1'b1; p_in_valid = 1'b1; p_sel = 3'd4;
        cyc();
        chk("p_valid", {31'd0, p_out_valid}, 32'd1);
        chk("p_data",  {16'd0, p_out_data},  32'hBEEF);
        chk("p_err",   {31'd0, p_out_err},   32'd0);
        for (int s = 5; s < 8; s++) begin
            p_sel = 3'(s);
            cyc();
            chk("p_oor_data", {16'd0, p_out_data}, 32'h0000);
            chk("p_oor_err",  {31'd0, p_out_err},  32'd1);
            chk("p_oor_sel",  {29'd0, p_out_sel},  32'(s));
        end
        chk("p_sticky", {31'd0, p_err_sticky}, 32'd1);
        p_in_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
- Parametrised, pipelined successor to the ALU's fixed 20:1 result-select mux.
- Selects one of NUM_SRC N-bit ALU functional-unit results by encoded index and registers the result.
- Carries it downstream over a valid/ready handshake through a 2-entry skid buffer.
- Flags out-of-range selects per result and in a sticky status bit. Sits between the ALU datapath units and the writeback stage.

Parameters:
- N, 8, data width of each source and of the result.
- NUM_SRC, 20, number of source channels (legal range 2..32).
- SEL_W, $clog2(NUM_SRC), select width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers sel and src.
- in_ready  output  1  block can accept this cycle.
- sel  input  SEL_W  source index.
- src  input  NUM_SRC*N  flattened sources; channel k at src[k*N +: N].
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_data  output  N  selected result.
- out_sel  output  SEL_W  index that produced out_data.
- out_err  output  1  result came from an out-of-range sel.
- err_clr  input  1  clears err_sticky.
- err_sticky  output  1  set by any accepted out-of-range sel.

Behaviour:
- Accept = in_valid && in_ready; pop = out_valid && out_ready.
- Decode: sel < NUM_SRC gives data = src[sel], err = 0. sel >= NUM_SRC gives data = 0, err = 1.
- Decode happens at accept time. The {data, sel, err} entry is captured; src may change freely after accept.
- Storage is a main register (drives out_*) plus a skid register.
- FSM state, registered:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main full, out_valid=1, in_ready=1.
  - TWO: main and skid full, out_valid=1, in_ready=0.
- EMPTY: accept loads main, goes to ONE.
- ONE:
  - accept and no pop: load skid, go to TWO.
  - accept and pop: load main with the new entry, stay in ONE.
  - pop and no accept: go to EMPTY.
  - otherwise hold.
- TWO: pop moves skid to main, go to ONE. No accept is possible (in_ready=0).
- Latency: 1 cycle from accept to out_valid when the buffer is EMPTY. Sustained throughput is 1 result/cycle with out_ready=1.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- out_data, out_sel and out_err stay stable while out_valid=1 and out_ready=0.
- in_ready comes directly from the state register (no combinational path from out_ready).
- err_sticky:
  - Set on the clock edge of an accept with an out-of-range sel.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset (asserted asynchronously, at any time including mid-transfer):
  - State goes to EMPTY and both registers go to 0.
  - Outputs: out_valid=0, out_data=0, out_sel=0, out_err=0, err_sticky=0, in_ready=1.
  - Any in-flight entries are discarded.
- Out of reset, the first accept is possible on the first edge after rst_n deasserts.

Decomposition:
- Package alu_sel_pkg holds:
  - the buffer state enum (EMPTY, ONE, TWO);
  - the entry struct-width helper;
  - named select constants for the default 20-source ALU map.
- One sub-module, alu_src_decode: combinational, parametrised N/NUM_SRC. It takes sel and src and returns data and err, including the range check.

Test Plan:
- Async reset: pulse rst_n low while in TWO with out_ready=0 -> out_valid=0, in_ready=1, err_sticky=0 immediately, before the next edge. Previous entries never appear.
- Basic select: sel=3, src ch3=0xA5, others 0xFF, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_sel=3, out_err=0.
- Backpressure: out_ready=0, accept 0x11 (sel 0), then 0x22 (sel 1) -> in_ready=0 after the second accept, and a third offer of 0x33 is held. Raise out_ready -> output order 0x11, 0x22, 0x33, each exactly once.
- Error path:
  - sel=20 -> out_data=0x00, out_err=1, err_sticky=1 one cycle after accept.
  - err_clr alone -> err_sticky=0 next cycle.
  - err_clr in the same cycle as another sel=25 accept -> err_sticky remains 1.
- Streaming: in_valid=1, out_ready=1, sel stepping 0..19 over 20 cycles with src chk=k+1 -> out_data 1..20 on consecutive cycles, and in_ready stays 1 throughout.
- Parametric instance, N=16, NUM_SRC=5 (SEL_W=3): sel=4 with src ch4=0xBEEF -> out_data 0xBEEF. sel=5, 6 and 7 each -> out_data 0x0000, out_err=1.
